flex_timer_array: RTL
=====================

FLEX_TIMER_ARRAY -- requirements
Module: flex_timer_array

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 8: count width per channel.
REQ-002 SHALL have parameter NUM_CH, default 4: number of independent channels.
REQ-003 SHALL have parameter PRESCALE_BITS, default 4: width of the shared prescaler.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port prescale_val  input  PRESCALE_BITS  tick period minus one.
REQ-007 SHALL have port count_enable  input  NUM_CH  per-channel advance enable.
REQ-008 SHALL have port clear  input  NUM_CH  per-channel synchronous clear.
REQ-009 SHALL have port load  input  NUM_CH  per-channel synchronous load.
REQ-010 SHALL have port mode  input  2*NUM_CH  per-channel cnt_mode_t: UP_WRAP=0, DOWN_WRAP=1, UP_ONCE=2, DOWN_ONCE=3.
REQ-011 SHALL have port load_val  input  NUM_CH*NUM_CNT_BITS  packed load values, channel 0 in LSBs.
REQ-012 SHALL have port rollover_val  input  NUM_CH*NUM_CNT_BITS  packed terminal/reload values.
REQ-013 SHALL have port count_out  output  NUM_CH*NUM_CNT_BITS  packed registered counts.
REQ-014 SHALL have port rollover_flag  output  NUM_CH  level: count at terminal value.
REQ-015 SHALL have port rollover_pulse  output  NUM_CH  one-cycle pulse when a count advance lands on terminal.
REQ-016 SHALL have port done  output  NUM_CH  sticky: one-shot channel halted.
REQ-017 SHALL have port tick  output  1  registered prescaler strobe.

Function
REQ-018 Prescaler SHALL free-run 0..prescale_val; tick=1 for the cycle after it reaches prescale_val; prescale_val=0 gives tick every cycle.
REQ-019 If prescaler > prescale_val (value lowered), the next count SHALL be 0.
REQ-020 A channel SHALL advance only in a cycle with count_enable[i]=1 and tick=1.
REQ-021 Per-channel priority SHALL be clear > load > advance > hold.
REQ-022 Clear SHALL set count=0, rollover_flag=0, done=0, rollover_pulse=0 next cycle.
REQ-023 Load SHALL set count=load_val, rollover_flag=(load_val==terminal), done=0, no pulse.
REQ-024 Terminal SHALL be rollover_val in UP modes and 1 in DOWN modes.
REQ-025 UP advance: count>=rollover_val -> 1, else count+1; sequence 1..rollover_val repeating.
REQ-026 DOWN advance: count<=1 or count>rollover_val -> rollover_val, else count-1.
REQ-027 rollover_flag SHALL update only on clear/load/advance and hold otherwise.
REQ-028 rollover_pulse SHALL be registered, high exactly one cycle per advance whose next count equals terminal.
REQ-029 Channel FSM SHALL have states COUNTING and HALTED; ONCE modes go COUNTING->HALTED on an advance reaching terminal, setting done=1.
REQ-030 HALTED SHALL ignore advances (count, flag held, no pulse); only clear or load returns to COUNTING.
REQ-031 rollover_val=0 SHALL make advances no-ops for that channel (count held, no flag/pulse).
REQ-032 mode change mid-count SHALL take effect on the next advance without reset of count.
REQ-033 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-034 n_rst low SHALL immediately force all counts=0, all flags/pulses/done=0, tick=0, prescaler=0, FSMs=COUNTING.
REQ-035 Reset mid-operation SHALL discard pending state; first advance after release follows REQ-025/026 from 0.

Structure
REQ-036 Package flex_pkg SHALL hold cnt_mode_t and FSM state typedef chan_state_t.
REQ-037 Per-channel logic SHALL be sub-module flex_chan, instantiated NUM_CH times via generate; prescaler in top level.

Verification
REQ-038 prescale_val=2, ch0 UP_WRAP rollover_val=3, enable: count 1,2,3,1 every 3rd cycle; flag high while 3; pulse once per wrap.
REQ-039 prescale_val=0, ch1 DOWN_ONCE rollover_val=4 from reset: 4,3,2,1 then hold 1, done=1; further enables no change; clear -> 0, done=0.
REQ-040 ch2 load=1 and clear=1 same cycle, load_val=5: count=0 (clear wins); next load alone -> count=5, no pulse.
REQ-041 ch0 UP_WRAP count=7, rollover_val lowered to 4: next advance -> 1; rollover_val=0: count holds.
REQ-042 Assert n_rst mid-count (ch0=6, done[1]=1): all outputs 0 asynchronously; after release first tick gives ch0=1.
REQ-043 All four channels enabled with distinct modes: each matches its independent reference model over 200 ticks.

Source files
------------

// File: rtl/flex_pkg.sv
// flex_pkg: shared types for the flex timer array.
//   cnt_mode_t   - per-channel counting mode (2-bit encoding on the mode port)
//   chan_state_t - per-channel control state (free counting / one-shot halted)
package flex_pkg;

  typedef enum logic [1:0] {
    UP_WRAP   = 2'd0,
    DOWN_WRAP = 2'd1,
    UP_ONCE   = 2'd2,
    DOWN_ONCE = 2'd3
  } cnt_mode_t;

  typedef enum logic {
    COUNTING = 1'b0,
    HALTED   = 1'b1
  } chan_state_t;

  // Bit 0 of the mode selects direction, bit 1 selects one-shot behaviour.
  function automatic logic mode_is_down(input cnt_mode_t m);
    return m[0];
  endfunction

  function automatic logic mode_is_once(input cnt_mode_t m);
    return m[1];
  endfunction

endpackage

// File: rtl/flex_chan.sv
// flex_chan: one independent counter channel of the flex timer array.
// Ports:
//   clk, n_rst      - clock (rising edge), asynchronous active-low reset
//   advance         - count step strobe (enable qualified by prescaler tick)
//   clear, load     - synchronous clear / load (clear has priority)
//   mode            - counting mode (up/down, wrap/once)
//   load_val        - value taken on load
//   rollover_val    - terminal value (up modes) and reload value (down modes)
//   count           - registered count
//   rollover_flag   - count sits at the terminal value
//   rollover_pulse  - one-cycle strobe when an advance lands on terminal
//   done            - sticky one-shot halted indication
module flex_chan
  import flex_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    advance,
  input  logic                    clear,
  input  logic                    load,
  input  cnt_mode_t               mode,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count,
  output logic                    rollover_flag,
  output logic                    rollover_pulse,
  output logic                    done
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

  chan_state_t             state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    pulse_q, pulse_d;
  logic [NUM_CNT_BITS-1:0] terminal;
  logic [NUM_CNT_BITS-1:0] adv_count;

  always_comb begin
    terminal  = mode_is_down(mode) ? CNT_ONE : rollover_val;
    adv_count = count_q;
    if (mode_is_down(mode)) begin
      // Out-of-range counts (above the reload value) restart from the reload value.
      if ((count_q <= CNT_ONE) || (count_q > rollover_val)) adv_count = rollover_val;
      else                                                  adv_count = count_q - CNT_ONE;
    end else begin
      if (count_q >= rollover_val) adv_count = CNT_ONE;
      else                         adv_count = count_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    flag_d  = flag_q;
    pulse_d = 1'b0;
    if (clear) begin
      state_d = COUNTING;
      count_d = '0;
      flag_d  = 1'b0;
    end else if (load) begin
      state_d = COUNTING;
      count_d = load_val;
      flag_d  = (load_val == terminal);
    end else if (advance && (rollover_val != '0)) begin
      unique case (state_q)
        COUNTING: begin
          count_d = adv_count;
          flag_d  = (adv_count == terminal);
          pulse_d = (adv_count == terminal);
          if (mode_is_once(mode) && (adv_count == terminal)) state_d = HALTED;
        end
        HALTED: ;
        default: state_d = COUNTING;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= COUNTING;
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
    end
  end

  assign count          = count_q;
  assign rollover_flag  = flag_q;
  assign rollover_pulse = pulse_q;
  assign done           = (state_q == HALTED);

endmodule

// File: rtl/flex_timer_array.sv
// flex_timer_array: NUM_CH independent counter channels sharing one prescaler.
// Ports:
//   clk, n_rst      - clock (rising edge), asynchronous active-low reset
//   prescale_val    - tick period minus one
//   count_enable    - per-channel advance enable (qualified by tick)
//   clear, load     - per-channel synchronous clear / load
//   mode            - per-channel cnt_mode_t, 2 bits each, channel 0 in LSBs
//   load_val        - packed per-channel load values, channel 0 in LSBs
//   rollover_val    - packed per-channel terminal/reload values
//   count_out       - packed per-channel registered counts
//   rollover_flag   - per-channel level: count at terminal
//   rollover_pulse  - per-channel one-cycle terminal strobe
//   done            - per-channel sticky one-shot halted
//   tick            - registered prescaler strobe
module flex_timer_array
  import flex_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS  = 8,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned PRESCALE_BITS = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [PRESCALE_BITS-1:0]       prescale_val,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              load,
  input  logic [2*NUM_CH-1:0]            mode,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              rollover_pulse,
  output logic [NUM_CH-1:0]              done,
  output logic                           tick
);

  localparam logic [PRESCALE_BITS-1:0] PRE_ONE = PRESCALE_BITS'(1);

  logic [PRESCALE_BITS-1:0] presc_q;
  logic                     tick_q;

  // Using >= for the wrap lets a lowered prescale_val restart the count at 0,
  // while tick only fires on an exact match.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q  <= (presc_q == prescale_val);
      presc_q <= (presc_q >= prescale_val) ? '0 : presc_q + PRE_ONE;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    flex_chan #(
      .NUM_CNT_BITS(NUM_CNT_BITS)
    ) u_chan (
      .clk           (clk),
      .n_rst         (n_rst),
      .advance       (count_enable[i] & tick_q),
      .clear         (clear[i]),
      .load          (load[i]),
      .mode          (cnt_mode_t'(mode[2*i +: 2])),
      .load_val      (load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_val  (rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .count         (count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_flag (rollover_flag[i]),
      .rollover_pulse(rollover_pulse[i]),
      .done          (done[i])
    );
  end

endmodule
